simprisc_hw_scoreboard: RTL

Synthesizable, parametrised in-order scoreboard for the simprisc bench, used in emulation and FPGA self-check builds where no UVM scoreboard runs. It holds NUM_CH independent expected-result FIFOs, each fed by a predictor stream. Every actual result from the DUT output monitor is compared against the head of its channel's FIFO under a bit mask. Per-channel match, mismatch and orphan counts are kept, and the first failure is captured for readback.

---
 rtl/simprisc_hw_scoreboard.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/simprisc_hw_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : simprisc_hw_scoreboard
// Purpose  : In-order hardware scoreboard with NUM_CH expected-result FIFOs.
//            Each actual word is compared under CMP_MASK against the head of
//            its channel FIFO. The module keeps per-channel match, mismatch and
//            orphan counts and captures the first failure for readback.
// Revision : 1.0  initial release
// ============================================================================
module simprisc_hw_scoreboard #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                NUM_CH   = 2,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] CMP_MASK = '1,
  localparam int               LVL_W    = $clog2(DEPTH + 1),
  localparam int               PTR_W    = $clog2(DEPTH),
  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         exp_valid,
  output logic [NUM_CH-1:0]         exp_ready,
  input  logic [NUM_CH*DATA_W-1:0]  exp_data,
  input  logic [NUM_CH-1:0]         act_valid,
  input  logic [NUM_CH*DATA_W-1:0]  act_data,
  output logic [NUM_CH*CNT_W-1:0]   match_cnt,
  output logic [NUM_CH*CNT_W-1:0]   mismatch_cnt,
  output logic [NUM_CH*CNT_W-1:0]   orphan_cnt,
  output logic [NUM_CH*LVL_W-1:0]   level,
  output logic                      err,
  output logic [CH_W-1:0]           err_ch,
  output logic [DATA_W-1:0]         err_exp,
  output logic [DATA_W-1:0]         err_act,
  output logic                      idle
);

  // Per-channel compare-stage results gathered for the shared error capture
  logic [NUM_CH-1:0]        err_evt;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH*DATA_W-1:0] cmp_exp_bus;
  logic [NUM_CH*DATA_W-1:0] cmp_act_bus;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  lvl;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              orphan;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] exp_w;
    logic [DATA_W-1:0] act_w;
    logic              cmp_v;
    logic              cmp_eq;
    logic              cmp_orph;
    logic [DATA_W-1:0] cmp_exp;
    logic [DATA_W-1:0] cmp_act;
    logic [CNT_W-1:0]  m_cnt;
    logic [CNT_W-1:0]  mm_cnt;
    logic [CNT_W-1:0]  o_cnt;
    logic              hit;
    logic              miss;
    logic              orph_evt;

    assign exp_w  = exp_data[c*DATA_W +: DATA_W];
    assign act_w  = act_data[c*DATA_W +: DATA_W];
    assign head   = mem[rd_ptr];
    assign empty  = (lvl == '0);
    assign full   = (lvl == LVL_W'(DEPTH));
    // Push/pop are decided on the occupancy before this edge: an actual
    // arriving on an empty FIFO is an orphan even if a push lands alongside.
    assign push   = exp_valid[c] && !full && !clear;
    assign pop    = act_valid[c] && !empty && !clear;
    assign orphan = act_valid[c] && empty;

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= exp_w;
      end
    end

    // Read/write pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        lvl    <= '0;
      end else if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        lvl    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   lvl <= lvl + LVL_W'(1);
          2'b01:   lvl <= lvl - LVL_W'(1);
          default: lvl <= lvl;
        endcase
      end
    end

    // Compare stage: register the masked-equal verdict and both words
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cmp_v    <= 1'b0;
        cmp_eq   <= 1'b0;
        cmp_orph <= 1'b0;
        cmp_exp  <= '0;
        cmp_act  <= '0;
      end else if (clear) begin
        cmp_v    <= 1'b0;
        cmp_eq   <= 1'b0;
        cmp_orph <= 1'b0;
        cmp_exp  <= '0;
        cmp_act  <= '0;
      end else begin
        cmp_v <= act_valid[c];
        if (act_valid[c]) begin
          cmp_orph <= orphan;
          cmp_eq   <= !orphan && (((head ^ act_w) & CMP_MASK) == '0);
          cmp_exp  <= orphan ? '0 : head;
          cmp_act  <= act_w;
        end
      end
    end

    assign hit      = cmp_v && !cmp_orph && cmp_eq;
    assign miss     = cmp_v && !cmp_orph && !cmp_eq;
    assign orph_evt = cmp_v && cmp_orph;

    // Saturating statistics counters fed from the compare stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_cnt  <= '0;
        mm_cnt <= '0;
        o_cnt  <= '0;
      end else if (clear) begin
        m_cnt  <= '0;
        mm_cnt <= '0;
        o_cnt  <= '0;
      end else begin
        if (hit && (m_cnt != '1))       m_cnt  <= m_cnt + CNT_W'(1);
        if (miss && (mm_cnt != '1))     mm_cnt <= mm_cnt + CNT_W'(1);
        if (orph_evt && (o_cnt != '1))  o_cnt  <= o_cnt + CNT_W'(1);
      end
    end

    assign exp_ready[c]                      = !full;
    assign level[c*LVL_W +: LVL_W]           = lvl;
    assign match_cnt[c*CNT_W +: CNT_W]       = m_cnt;
    assign mismatch_cnt[c*CNT_W +: CNT_W]    = mm_cnt;
    assign orphan_cnt[c*CNT_W +: CNT_W]      = o_cnt;
    assign err_evt[c]                        = miss || orph_evt;
    assign busy[c]                           = cmp_v || !empty;
    assign cmp_exp_bus[c*DATA_W +: DATA_W]   = cmp_exp;
    assign cmp_act_bus[c*DATA_W +: DATA_W]   = cmp_act;
  end

  logic [CH_W-1:0]   sel_ch;
  logic [DATA_W-1:0] sel_exp;
  logic [DATA_W-1:0] sel_act;

  // Pick the lowest-index channel among simultaneous error events
  always_comb begin
    sel_ch  = '0;
    sel_exp = '0;
    sel_act = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_evt[i]) begin
        sel_ch  = CH_W'(i);
        sel_exp = cmp_exp_bus[i*DATA_W +: DATA_W];
        sel_act = cmp_act_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // First-error capture; frozen once err is set until clear or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_ch  <= '0;
      err_exp <= '0;
      err_act <= '0;
    end else if (clear) begin
      err     <= 1'b0;
      err_ch  <= '0;
      err_exp <= '0;
      err_act <= '0;
    end else if (!err && (|err_evt)) begin
      err     <= 1'b1;
      err_ch  <= sel_ch;
      err_exp <= sel_exp;
      err_act <= sel_act;
    end
  end

  assign idle = ~(|busy);

endmodule
`default_nettype wire
